// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of an external 1W/1R RAM with 1-cycle read latency.
// A 3-entry skid buffer after the RAM keeps 1 word/cycle throughput with first-word fall-through output.
module ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MASK_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_wr_en,
  output logic [MASK_WIDTH-1:0] ram_wr_mask,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam int LW = ADDR_WIDTH + 2;

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_skid [3];
  logic [1:0]            r_skid_cnt;
  logic [LW-1:0]         r_level;

  logic       w_ram_full;
  logic       w_ram_empty;
  logic       w_push;
  logic       w_pop;
  logic       w_issue;
  logic [1:0] w_cap_idx;

  assign w_ram_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                       (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
  assign w_ram_empty = (r_wr_ptr == r_rd_ptr);

  // Issue only when the skid can absorb the returning word: skid + in-flight must stay <= 3.
  assign w_issue = !reset && !w_ram_empty &&
                   (({1'b0, r_skid_cnt} + {2'b00, r_inflight}) < 3'd3);

  assign in_ready  = !reset && !w_ram_full;
  assign w_push    = in_valid && in_ready;
  assign out_valid = (r_skid_cnt != 2'd0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_skid[0];
  assign level     = r_level;

  assign ram_wr_en   = w_push;
  assign ram_wr_mask = '1;
  assign ram_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = in_data;
  assign ram_rd_en   = w_issue;
  assign ram_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  // Captured word lands behind the entries that remain after this cycle's pop.
  assign w_cap_idx = r_skid_cnt - 2'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_skid_cnt <= 2'd0;
      r_level    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_inflight <= w_issue;
      if (w_pop) begin
        r_skid[0] <= r_skid[1];
        r_skid[1] <= r_skid[2];
      end
      if (r_inflight) r_skid[w_cap_idx] <= ram_rd_data;
      r_skid_cnt <= r_skid_cnt + 2'(r_inflight) - 2'(w_pop);
      if (w_push && !w_pop) r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
    end
  end

endmodule
